// File: rtl/dec_to_bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package dec_pkg;

  localparam int DIGITS  = 3;
  localparam int ITER    = 10;
  localparam int ACC_W   = 10;
  localparam int BIN_W   = 8;
  localparam int BIN_MAX = 255;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // True when a BCD digit is a legal decimal digit (0..9).
  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/dec_to_bin_if.sv
// Request/result bundle of the converter.
// Handshake: start is a request sampled only while the converter is idle;
// busy is high from the accepting edge until the edge that raises done;
// done is a one-cycle pulse marking bin/err/ovf valid, which then hold
// until the next accepted start (err/ovf clear there, bin holds until done).
interface dec_to_bin_if;
  import dec_pkg::*;

  logic               start;
  logic [3:0]         bit3;
  logic [3:0]         bit2;
  logic [3:0]         bit1;
  logic [BIN_W-1:0]   bin;
  logic               busy;
  logic               done;
  logic               err;
  logic               ovf;
  state_t             state;

  modport master (
    output start, bit3, bit2, bit1,
    input  bin, busy, done, err, ovf, state
  );

  modport slave (
    input  start, bit3, bit2, bit1,
    output bin, busy, done, err, ovf, state
  );

endinterface

// File: rtl/dec_to_bin_adj.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 if >= 8.
module bcd_adj_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Digits of 8 or more came from a halved tens-carry and need the fixup.
  always_comb begin
    q = d;
    if (d >= 4'd8) q = d - 4'd3;
  end

endmodule

// File: rtl/dec_to_bin.sv
// Three-digit BCD to 8-bit binary converter (reverse double-dabble),
// with invalid-digit error and saturation above 255.
module dec_to_bin
  import dec_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  dec_to_bin_if.slave   bus
);

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd, bcd_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIN_W-1:0]   bin_q, bin_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               err_q, err_nxt;
  logic               ovf_q, ovf_nxt;

  logic [BCD_W+ACC_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_sh;
  logic [BCD_W-1:0]       bcd_adj;
  logic [ACC_W-1:0]       acc_sh;

  assign shifted = {bcd, acc} >> 1;
  assign bcd_sh  = shifted[BCD_W+ACC_W-1:ACC_W];
  assign acc_sh  = shifted[ACC_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj_digit u_adj (
      .d (bcd_sh[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bcd    <= '0;
      acc    <= '0;
      cnt    <= '0;
      bin_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      bcd    <= bcd_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      bin_q  <= bin_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  // Next-state and next-output logic; done is a pulse, everything else holds.
  always_comb begin
    state_nxt = state;
    bcd_nxt   = bcd;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    bin_nxt   = bin_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    err_nxt   = err_q;
    ovf_nxt   = ovf_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          bcd_nxt  = {bus.bit3, bus.bit2, bus.bit1};
          acc_nxt  = '0;
          cnt_nxt  = '0;
          err_nxt  = 1'b0;
          ovf_nxt  = 1'b0;
          busy_nxt = 1'b1;
          if (!digit_ok(bus.bit3) || !digit_ok(bus.bit2) || !digit_ok(bus.bit1)) begin
            err_nxt   = 1'b1;
            state_nxt = FINISH;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_nxt = bcd_adj;
        acc_nxt = acc_sh;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(ITER - 1)) state_nxt = FINISH;
      end
      FINISH: begin
        // Overflow is judged on the full accumulator, not its low byte.
        if (err_q) begin
          bin_nxt = '0;
        end else if (acc > ACC_W'(BIN_MAX)) begin
          bin_nxt = BIN_W'(BIN_MAX);
          ovf_nxt = 1'b1;
        end else begin
          bin_nxt = acc[BIN_W-1:0];
        end
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.bin   = bin_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.ovf   = ovf_q;
  assign bus.state = state;

endmodule

// File: tb/tb_dec_to_bin.sv
// Bench for dec_to_bin: directed corner cases plus random digit triples
// checked against a decimal-arithmetic reference model.
module tb_dec_to_bin;
  import dec_pkg::*;

  logic clk;
  logic rst_n;

  dec_to_bin_if bus ();

  dec_to_bin u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];    // {err, ovf, bin}
  logic [7:0] last_bin = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal value, then error/saturation rules.
  function automatic logic [9:0] model(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    int v;
    if (h > 9 || t > 9 || o > 9) return {1'b1, 1'b0, 8'd0};
    v = int'(h) * 100 + int'(t) * 10 + int'(o);
    if (v > 255) return {1'b0, 1'b1, 8'd255};
    return {2'b00, 8'(v)};
  endfunction

  // Driver: one start pulse, wait for done, check result and timing.
  task automatic run_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                          input string tag);
    int k;
    int busy_cnt;
    int lat;
    logic [9:0] e;
    e = model(h, t, o);
    lat = e[9] ? 1 : 11;
    exp_q.push_back(e);
    bus.bit3  = h;
    bus.bit2  = t;
    bus.bit1  = o;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_rise"}, bus.busy, 1);
    check({tag, "_err_at_start"}, bus.err, e[9]);
    check({tag, "_ovf_clear"}, bus.ovf, 0);
    check({tag, "_bin_hold"}, bus.bin, last_bin);
    k = 0;
    busy_cnt = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, lat);
    check({tag, "_busy_cycles"}, busy_cnt, lat);
    check({tag, "_busy_fall"}, bus.busy, 0);
    e = exp_q.pop_front();
    check({tag, "_bin"}, bus.bin, e[7:0]);
    check({tag, "_err"}, bus.err, e[9]);
    check({tag, "_ovf"}, bus.ovf, e[8]);
    last_bin = e[7:0];
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_bin_held"}, bus.bin, last_bin);
  endtask

  initial begin
    int k;
    int pulses;
    int t_prev;
    logic [9:0] e;

    bus.start = 1'b0;
    bus.bit3  = 4'd0;
    bus.bit2  = 4'd0;
    bus.bit1  = 4'd0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bin", bus.bin, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_state", bus.state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values and boundaries
    run_conv(4'd1, 4'd2, 4'd3, "d123");
    run_conv(4'd2, 4'd5, 4'd5, "d255");
    run_conv(4'd2, 4'd5, 4'd6, "d256");
    run_conv(4'd9, 4'd9, 4'd9, "d999");
    run_conv(4'd0, 4'd0, 4'd0, "d000");
    run_conv(4'd1, 4'd10, 4'd3, "bad_tens");
    run_conv(4'd0, 4'd4, 4'd2, "err_clear");

    // Digits and start toggled while busy: original value, one done only
    bus.bit3 = 4'd1; bus.bit2 = 4'd2; bus.bit1 = 4'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bit3 = 4'd0; bus.bit2 = 4'd4; bus.bit1 = 4'd2;
    pulses = 0;
    for (int i = 1; i <= 25; i++) begin
      bus.start = (i == 2 || i == 4 || i == 6);
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        check("busy_ignore_bin", bus.bin, 123);
      end
    end
    bus.start = 1'b0;
    check("busy_ignore_pulses", pulses, 1);
    last_bin = 8'd123;

    // start held high: done every 12 cycles
    bus.bit3 = 4'd0; bus.bit2 = 4'd4; bus.bit1 = 4'd2; bus.start = 1'b1;
    pulses = 0;
    t_prev = -1;
    k = 0;
    while (pulses < 3 && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.done) begin
        pulses++;
        check("held_bin", bus.bin, 42);
        if (t_prev >= 0) check("held_period", k - t_prev, 12);
        t_prev = k;
      end
    end
    check("held_pulses", pulses, 3);
    bus.start = 1'b0;
    k = 0;
    while ((bus.busy || bus.done) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("held_drain", bus.busy, 0);

    // Reset in the middle of SHIFT: lost conversion, no done
    bus.bit3 = 4'd1; bus.bit2 = 4'd2; bus.bit1 = 4'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_state_shift", bus.state, SHIFT);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bin", bus.bin, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_err", bus.err, 0);
    check("mid_rst_ovf", bus.ovf, 0);
    check("mid_rst_state", bus.state, IDLE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    last_bin = 8'd0;
    run_conv(4'd0, 4'd0, 4'd7, "after_rst");

    // Random triples, occasionally with an illegal digit
    for (int i = 0; i < 30; i++) begin
      logic [3:0] h, t, o;
      h = 4'($urandom_range(0, 11));
      t = 4'($urandom_range(0, 11));
      o = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) t = 4'($urandom_range(10, 15));
      run_conv(h, t, o, $sformatf("rnd%0d_%0d%0d%0d", i, h, t, o));
    end

    e = model(4'd0, 4'd0, 4'd0);
    check("queue_empty", exp_q.size(), 0);
    check("model_zero", e, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
